// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline front end.
//   DEF_ADDR_W / DEF_INST_W : default address and instruction widths
//   INST_NOP                : canonical no-op (MOV r0, r0)
//   fetch_state_e           : instruction-fetch sequencer states
package arm_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;

  localparam logic [DEF_INST_W-1:0] INST_NOP = 32'hE1A0_0000;

  // ST_FETCH : request outstanding (or about to be) for the current pc
  // ST_HOLD  : a response arrived under freeze and is parked in the buffer
  // ST_DRAIN : a redirect happened while a request was in flight; its data is dropped
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst              : clock, synchronous active-low reset
//   load                  : capture {pc_in, inst_in} and mark valid
//   flush                 : clear valid (pc/inst keep their old values); wins over load
//   pc_in, inst_in        : next contents
//   pc_out, inst_out      : registered PC+4 and instruction
//   valid_out             : register holds a live instruction
module if_id_reg
  import arm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [INST_W-1:0] inst_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              valid_out
);

  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [INST_W-1:0] inst_q,  inst_d;
  logic              valid_q, valid_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_in;
      inst_d  = inst_in;
      valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign inst_out  = inst_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the single-outstanding instruction-memory
// handshake and feeds the IF/ID register.
//   clk, rst                  : clock, synchronous active-low reset
//   freeze                    : hazard stall, holds PC and IF/ID
//   branch_taken, branch_addr : one-cycle redirect from EXE (beats freeze)
//   imem_req, imem_addr       : registered request; address stable until answered
//   imem_rdata, imem_valid    : response; valid only counts while imem_req=1
//   id_pc, id_inst, id_valid  : IF/ID contents (id_pc is PC+4)
module fetch_stage
  import arm_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  fetch_state_e      state_q,    state_d;
  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              req_q,      req_d;
  logic [ADDR_W-1:0] buf_pc_q,   buf_pc_d;
  logic [INST_W-1:0] buf_inst_q, buf_inst_d;

  logic              id_load, id_flush;
  logic [ADDR_W-1:0] id_pc_in;
  logic [INST_W-1:0] id_inst_in;
  logic [ADDR_W-1:0] pc_inc;
  logic              resp;

  // A response only counts against a live request; this also masks
  // stray valids in the first cycle after reset and while parked.
  assign resp   = imem_valid & req_q;
  assign pc_inc = pc_q + ADDR_W'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    id_load    = 1'b0;
    id_flush   = 1'b0;
    id_pc_in   = pc_inc;
    id_inst_in = imem_rdata;

    if (branch_taken) begin
      pc_d     = branch_addr;
      id_flush = 1'b1;
      unique case (state_q)
        // In-flight request must still be answered before the new one goes out.
        ST_FETCH: state_d = resp ? ST_FETCH : ST_DRAIN;
        ST_HOLD:  state_d = ST_FETCH;
        ST_DRAIN: state_d = ST_DRAIN;
        default:  state_d = ST_FETCH;
      endcase
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (resp) begin
            if (freeze) begin
              buf_pc_d   = pc_inc;
              buf_inst_d = imem_rdata;
              state_d    = ST_HOLD;
            end else begin
              id_load = 1'b1;
              pc_d    = pc_inc;
            end
          end else if (!freeze) begin
            id_flush = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!freeze) begin
            id_load    = 1'b1;
            id_pc_in   = buf_pc_q;
            id_inst_in = buf_inst_q;
            pc_d       = pc_inc;
            state_d    = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (resp) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end

    // A new request is launched only on entry to (or advance within) FETCH;
    // in DRAIN the stale address must stay on the bus until answered.
    req_d  = (state_d != ST_HOLD);
    addr_d = (state_d == ST_FETCH) ? pc_d : addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      buf_pc_q   <= '0;
      buf_inst_q <= INST_NOP;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load      (id_load),
    .flush     (id_flush),
    .pc_in     (id_pc_in),
    .inst_in   (id_inst_in),
    .pc_out    (id_pc),
    .inst_out  (id_inst),
    .valid_out (id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A behavioural memory answers each
// request after a programmable latency with data = addr ^ 0xA5. The
// reference model tracks the program-order instruction stream: every
// instruction entering IF/ID must be the next sequential one after the
// last delivered instruction or redirect target.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] SALT     = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_valid     (id_valid)
  );

  // ---------------- memory model ----------------
  // mem_lat = N>0: answer on the Nth cycle of a request (1 = zero-wait).
  // mem_lat = 0  : random latency 1..4 per request.
  int          mem_lat = 1;
  int          req_lat = 1;
  int          mem_cnt = 0;
  logic        m_req   = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_addr  = '0;

  always @(posedge clk) begin
    m_req   <= imem_req;
    m_valid <= imem_valid;
    m_addr  <= imem_addr;
    if (!rst || (imem_req && imem_valid)) begin
      mem_cnt <= 0;
      req_lat <= $urandom_range(1, 4);
    end else if (imem_req) begin
      mem_cnt <= mem_cnt + 1;
    end
  end

  always @(negedge clk) begin
    imem_valid = imem_req && (mem_cnt >= ((mem_lat == 0) ? req_lat : mem_lat) - 1);
    imem_rdata = imem_valid ? (imem_addr ^ SALT) : 32'h0;
  end

  // ---------------- checking ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          deliveries = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] o_pc = '0;
  logic [31:0] o_inst = '0;
  logic        o_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply current inputs, then compare outputs against the model.
  task automatic tick();
    logic        f, b, r;
    logic [31:0] ba;
    f  = freeze;
    b  = branch_taken;
    r  = rst;
    ba = branch_addr;
    @(posedge clk);
    @(negedge clk);
    #1;
    if (!r) begin
      check("rst_id_valid", id_valid, 0);
      check("rst_id_pc",    id_pc,    0);
      check("rst_id_inst",  id_inst,  0);
      check("rst_req",      imem_req, 0);
      exp_pc = RESET_PC;
    end else begin
      if (m_req && !m_valid) begin
        check("req_held",    imem_req,  1);
        check("addr_stable", imem_addr, m_addr);
      end
      if (b) begin
        check("br_id_valid", id_valid, 0);
        check("br_id_pc",    id_pc,    o_pc);
        check("br_id_inst",  id_inst,  o_inst);
        exp_pc = ba;
      end else if (f) begin
        check("frz_id_valid", id_valid, o_valid);
        check("frz_id_pc",    id_pc,    o_pc);
        check("frz_id_inst",  id_inst,  o_inst);
      end else if (id_valid) begin
        check("seq_id_pc",   id_pc,   exp_pc + 32'd4);
        check("seq_id_inst", id_inst, exp_pc ^ SALT);
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
    end
    o_pc    = id_pc;
    o_inst  = id_inst;
    o_valid = id_valid;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // ---- zero-wait streaming ----
    mem_lat = 1;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("zw_req",  imem_req,  1);
      check("zw_addr", imem_addr, (k - 1) * 4);
      if (k >= 2) begin
        check("zw_id_valid", id_valid, 1);
        check("zw_id_pc",    id_pc,    (k - 1) * 4);
      end
    end

    // ---- latency 3, no stalls ----
    mem_lat = 3;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("l3_addr",     imem_addr, ((k - 1) / 3) * 4);
      check("l3_id_valid", id_valid,  (k >= 4 && (k - 1) % 3 == 0) ? 1 : 0);
    end

    // ---- freeze while response for 0x8 returns ----
    mem_lat = 1;
    do_reset();
    repeat (3) tick();
    freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("frz_req",      imem_req, 0);
      check("frz_hold_pc",  id_pc,    32'h8);
      check("frz_hold_val", id_valid, 1);
    end
    freeze = 1'b0;
    tick();
    check("unfrz_id_pc",   id_pc,     32'hC);
    check("unfrz_id_inst", id_inst,   32'h8 ^ SALT);
    check("unfrz_addr",    imem_addr, 32'hC);
    check("unfrz_req",     imem_req,  1);

    // ---- redirect while a latency-5 request for 0x10 is pending ----
    mem_lat = 1;
    do_reset();
    repeat (4) tick();
    mem_lat = 5;
    tick();
    check("pend_addr", imem_addr, 32'h10);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    tick();
    check("drn_id_valid", id_valid,  0);
    check("drn_addr",     imem_addr, 32'h10);
    branch_taken = 1'b0;
    repeat (3) begin
      tick();
      check("drn_stale_addr", imem_addr, 32'h10);
      check("drn_no_valid",   id_valid,  0);
    end
    mem_lat = 1;
    tick();
    check("drn_new_addr", imem_addr, 32'h100);
    tick();
    check("drn_first_pc",   id_pc,    32'h104);
    check("drn_first_inst", id_inst,  32'h100 ^ SALT);
    check("drn_first_val",  id_valid, 1);

    // ---- branch + freeze together, then branch again inside DRAIN ----
    mem_lat = 1;
    do_reset();
    repeat (3) tick();
    mem_lat      = 4;
    freeze       = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h180;
    tick();
    check("bf_id_valid", id_valid,  0);
    check("bf_addr",     imem_addr, 32'h180);
    freeze      = 1'b0;
    branch_addr = 32'h1C0;
    tick();
    check("bd_addr1", imem_addr, 32'h180);
    branch_addr = 32'h200;
    tick();
    check("bd_addr2", imem_addr, 32'h180);
    branch_taken = 1'b0;
    freeze       = 1'b1;
    tick();
    check("bd_addr3", imem_addr, 32'h180);
    mem_lat = 1;
    tick();
    check("bd_resume_addr", imem_addr, 32'h200);
    freeze = 1'b0;
    tick();
    check("bd_first_pc",  id_pc,    32'h204);
    check("bd_first_val", id_valid, 1);

    // ---- PC wrap, then reset in the middle of a request ----
    mem_lat = 1;
    do_reset();
    tick();
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    tick();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    tick();
    check("wrap_id_pc",   id_pc,     32'h0);
    check("wrap_id_inst", id_inst,   32'hFFFF_FFFC ^ SALT);
    check("wrap_addr0",   imem_addr, 32'h0);
    mem_lat = 4;
    tick();
    tick();
    check("midreq_req", imem_req, 1);
    rst = 1'b0;
    tick();
    rst     = 1'b1;
    mem_lat = 1;
    tick();
    check("rst_restart_addr", imem_addr, RESET_PC);
    check("rst_restart_req",  imem_req,  1);
    tick();
    check("rst_restart_pc", id_pc, RESET_PC + 32'd4);

    // ---- randomized traffic against the stream model ----
    mem_lat = 0;
    do_reset();
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      freeze       = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 19) == 0);
      branch_addr  = $urandom;
      if ($urandom_range(0, 3) != 0) branch_addr[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) branch_addr = 32'hFFFF_FFF4;
      rst = ($urandom_range(0, 499) != 0);
      tick();
    end
    check("progress", (deliveries > 200) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
